// File: rtl/ebpc_pkg.sv
// EBPC shared types and constants for the decoder job sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ebpc_pkg;

  // Data word width of the symbol decoder; one BPC block produces DATA_W+1 pushes.
  localparam int unsigned DATA_W         = 8;
  localparam int unsigned PUSH_PER_BLOCK = DATA_W + 1;
  localparam int unsigned PUSH_CNT_W     = $clog2(PUSH_PER_BLOCK + 1);

  typedef enum logic [2:0] {
    DS_IDLE  = 3'd0,
    DS_CLEAR = 3'd1,
    DS_RUN   = 3'd2,
    DS_DONE  = 3'd3,
    DS_ERROR = 3'd4
  } dec_seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_PUSH_CNT = 2'd1,
    ERR_WATCHDOG = 2'd2
  } err_code_t;

endpackage

// File: rtl/ebpc_dec_seq_watchdog.sv
// Saturating idle counter for the decoder sequencer; expire_o fires on the increment that reaches WD_CYCLES.
// Latency: expire_o is combinational from the counter state and inc_i.
// Backpressure: none; clr_i wins over inc_i.
// Ports: clk_i/rst_ni, clr_i (zero the counter), inc_i (count one idle cycle), expire_o.
module dec_seq_watchdog #(
  parameter int unsigned WD_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int unsigned W = $clog2(WD_CYCLES + 1);

  logic [W-1:0] cnt_q;

  // Fire on the cycle the count would reach WD_CYCLES so the sequencer reacts on cycle WD_CYCLES.
  assign expire_o = inc_i && (cnt_q == W'(WD_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != W'(WD_CYCLES))) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ebpc_dec_seq.sv
// Job-level sequencer for the EBPC symbol decoder: soft-clear, run N blocks, report done/error.
// Latency: done_o one cycle after the last block's vld; CLEAR costs one cycle after start.
// Backpressure: upstream valid/ready gated off between blocks once N blocks have started; dec_rdy_o follows ds_rdy_i in RUN only.
// Ports: job control (start_i, num_blocks_i, abort_i), status (busy_o, done_o, err_o, err_code_o,
//        blocks_done_o), unpacker/decoder data handshake (up_*, dec_data_*), decoder output side
//        (ds_rdy_i, dec_rdy_o, dec_push_i, dec_vld_i) and decoder soft clear dec_clr_o.
// Optional: define EBPC_DEC_SEQ_WATCHDOG_EN to add an idle watchdog (error code WATCHDOG).
module ebpc_dec_seq
  import ebpc_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned WD_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_blocks_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [CNT_W-1:0] blocks_done_o,
  input  logic             up_vld_i,
  output logic             up_rdy_o,
  output logic             dec_data_vld_o,
  input  logic             dec_data_rdy_i,
  input  logic             ds_rdy_i,
  output logic             dec_rdy_o,
  input  logic             dec_push_i,
  input  logic             dec_vld_i,
  output logic             dec_clr_o
);

  dec_seq_state_t        state_q;
  err_code_t             err_code_q;
  logic [CNT_W-1:0]      num_blocks_q;
  logic [CNT_W-1:0]      blocks_done_q;
  logic [CNT_W-1:0]      blocks_started_q;
  logic [PUSH_CNT_W-1:0] push_cnt_q;
  logic                  err_entry_q;

  logic                  in_run;
  logic                  gate;
  logic [PUSH_CNT_W-1:0] push_nxt;
  logic [CNT_W-1:0]      blocks_done_inc;
  logic                  wd_expire;

  assign in_run          = (state_q == DS_RUN);
  assign push_nxt        = push_cnt_q + PUSH_CNT_W'(dec_push_i);
  assign blocks_done_inc = blocks_done_q + 1'b1;

  // Only close the gate between blocks: the decoder's zero-run state needs valid held high mid-block.
  assign gate = in_run && !((push_cnt_q == '0) && (blocks_started_q == num_blocks_q));

  assign up_rdy_o       = dec_data_rdy_i & gate;
  assign dec_data_vld_o = up_vld_i & gate;
  assign dec_rdy_o      = ds_rdy_i & in_run;

  // Abort clears the decoder in the same cycle so no partial block survives into the next job.
  assign dec_clr_o = (state_q == DS_CLEAR) | err_entry_q |
                     (abort_i & ((state_q == DS_CLEAR) | in_run));

  assign busy_o        = (state_q == DS_CLEAR) | in_run;
  assign done_o        = (state_q == DS_DONE);
  assign err_o         = (state_q == DS_ERROR);
  assign err_code_o    = err_code_q;
  assign blocks_done_o = blocks_done_q;

`ifdef EBPC_DEC_SEQ_WATCHDOG_EN
  logic wd_inc;
  logic wd_clr;

  // Only count idle cycles the decoder itself is responsible for: input present and output ready.
  assign wd_inc = in_run & up_vld_i & ds_rdy_i & ~dec_push_i;
  assign wd_clr = ~in_run | dec_push_i;

  dec_seq_watchdog #(
    .WD_CYCLES (WD_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (wd_clr),
    .inc_i    (wd_inc),
    .expire_o (wd_expire)
  );
`else
  logic unused_wd_cycles;

  assign unused_wd_cycles = ^WD_CYCLES;
  assign wd_expire        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= DS_IDLE;
      err_code_q       <= ERR_NONE;
      num_blocks_q     <= '0;
      blocks_done_q    <= '0;
      blocks_started_q <= '0;
      push_cnt_q       <= '0;
      err_entry_q      <= 1'b0;
    end else begin
      err_entry_q <= 1'b0;
      case (state_q)
        DS_IDLE, DS_ERROR: begin
          if (abort_i) begin
            state_q    <= DS_IDLE;
            err_code_q <= ERR_NONE;
          end else if (start_i) begin
            num_blocks_q     <= num_blocks_i;
            blocks_done_q    <= '0;
            blocks_started_q <= '0;
            push_cnt_q       <= '0;
            err_code_q       <= ERR_NONE;
            state_q          <= DS_CLEAR;
          end
        end

        DS_CLEAR: begin
          if (abort_i) begin
            state_q <= DS_IDLE;
          end else if (num_blocks_q == '0) begin
            state_q <= DS_DONE;
          end else begin
            state_q <= DS_RUN;
          end
        end

        DS_RUN: begin
          if (abort_i) begin
            state_q    <= DS_IDLE;
            push_cnt_q <= '0;
          end else begin
            if (dec_push_i && (push_cnt_q == '0)) begin
              blocks_started_q <= blocks_started_q + 1'b1;
            end
            if (dec_vld_i) begin
              if (push_nxt != PUSH_CNT_W'(PUSH_PER_BLOCK)) begin
                err_code_q  <= ERR_PUSH_CNT;
                err_entry_q <= 1'b1;
                state_q     <= DS_ERROR;
              end else begin
                push_cnt_q <= '0;
                if (blocks_done_q != num_blocks_q) begin
                  blocks_done_q <= blocks_done_inc;
                end
                if (blocks_done_inc == num_blocks_q) begin
                  state_q <= DS_DONE;
                end
              end
            end else if (wd_expire) begin
              err_code_q  <= ERR_WATCHDOG;
              err_entry_q <= 1'b1;
              state_q     <= DS_ERROR;
            end else begin
              push_cnt_q <= push_nxt;
            end
          end
        end

        DS_DONE: begin
          state_q <= DS_IDLE;
        end

        default: begin
          state_q <= DS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ebpc_dec_seq.sv
// Directed bench for ebpc_dec_seq: job run, empty job, push-count error, abort, zero-run gating, watchdog.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_ebpc_dec_seq;

  localparam int CNT_W = 16;
  localparam int PPB   = 9;   // DATA_W + 1 pushes per block with DATA_W = 8

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             start_i;
  logic [CNT_W-1:0] num_blocks_i;
  logic             abort_i;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [1:0]       err_code_o;
  logic [CNT_W-1:0] blocks_done_o;
  logic             up_vld_i;
  logic             up_rdy_o;
  logic             dec_data_vld_o;
  logic             dec_data_rdy_i;
  logic             ds_rdy_i;
  logic             dec_rdy_o;
  logic             dec_push_i;
  logic             dec_vld_i;
  logic             dec_clr_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  ebpc_dec_seq #(
    .CNT_W     (CNT_W),
    .WD_CYCLES (16)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .num_blocks_i   (num_blocks_i),
    .abort_i        (abort_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .err_code_o     (err_code_o),
    .blocks_done_o  (blocks_done_o),
    .up_vld_i       (up_vld_i),
    .up_rdy_o       (up_rdy_o),
    .dec_data_vld_o (dec_data_vld_o),
    .dec_data_rdy_i (dec_data_rdy_i),
    .ds_rdy_i       (ds_rdy_i),
    .dec_rdy_o      (dec_rdy_o),
    .dec_push_i     (dec_push_i),
    .dec_vld_i      (dec_vld_i),
    .dec_clr_o      (dec_clr_o)
  );

  // Inputs change 2 time units after the rising edge; outputs are read 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic start_job(input logic [CNT_W-1:0] n);
    start_i      = 1'b1;
    num_blocks_i = n;
    tick();
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; start_i = 1'b0; num_blocks_i = '0; abort_i = 1'b0;
    up_vld_i = 1'b1; dec_data_rdy_i = 1'b1; ds_rdy_i = 1'b1;
    dec_push_i = 1'b0; dec_vld_i = 1'b0;
    repeat (3) tick();
    #1;
    tests++; if ({busy_o, done_o, err_o, dec_clr_o} !== 4'b0000) begin fails++; $display("FAIL reset_flags got=%b exp=0000", {busy_o, done_o, err_o, dec_clr_o}); end
    tests++; if (err_code_o !== 2'd0 || blocks_done_o !== '0) begin fails++; $display("FAIL reset_cnt code=%0d blocks=%0d exp=0/0", err_code_o, blocks_done_o); end
    tests++; if (dec_data_vld_o !== 1'b0 || up_rdy_o !== 1'b0 || dec_rdy_o !== 1'b0) begin fails++; $display("FAIL reset_gate vld=%b rdy=%b drdy=%b exp=0", dec_data_vld_o, up_rdy_o, dec_rdy_o); end
    rst_ni = 1'b1;
    tick();
    // abort wins over start in IDLE
    start_i = 1'b1; abort_i = 1'b1; num_blocks_i = 16'd5;
    tick();
    start_i = 1'b0; abort_i = 1'b0;
    #1;
    tests++; if (busy_o !== 1'b0 || dec_clr_o !== 1'b0) begin fails++; $display("FAIL abort_beats_start busy=%b clr=%b exp=0/0", busy_o, dec_clr_o); end
  endtask

  task automatic test_three_blocks();
    start_job(16'd3);
    #1;
    tests++; if (dec_clr_o !== 1'b1 || busy_o !== 1'b1 || dec_data_vld_o !== 1'b0) begin fails++; $display("FAIL run3_clear clr=%b busy=%b vld=%b exp=1/1/0", dec_clr_o, busy_o, dec_data_vld_o); end
    tick();
    #1;
    tests++; if (dec_clr_o !== 1'b0 || dec_data_vld_o !== 1'b1 || dec_rdy_o !== 1'b1) begin fails++; $display("FAIL run3_run clr=%b vld=%b drdy=%b exp=0/1/1", dec_clr_o, dec_data_vld_o, dec_rdy_o); end
    for (int b = 0; b < 3; b++) begin
      for (int p = 0; p < PPB; p++) begin
        dec_push_i = 1'b1;
        dec_vld_i  = (p == PPB - 1);
        tick();
        if (b == 2 && p == 4) begin
          #1;
          tests++; if (dec_data_vld_o !== 1'b1) begin fails++; $display("FAIL run3_midblk3_gate vld=%b exp=1", dec_data_vld_o); end
        end
      end
      dec_push_i = 1'b0; dec_vld_i = 1'b0;
      if (b < 2) begin
        #1;
        tests++; if (blocks_done_o !== CNT_W'(b + 1) || done_o !== 1'b0) begin fails++; $display("FAIL run3_blk%0d blocks=%0d done=%b exp=%0d/0", b, blocks_done_o, done_o, b + 1); end
      end
    end
    #1;
    tests++; if (done_o !== 1'b1 || blocks_done_o !== 16'd3 || err_o !== 1'b0) begin fails++; $display("FAIL run3_done done=%b blocks=%0d err=%b exp=1/3/0", done_o, blocks_done_o, err_o); end
    tests++; if (dec_data_vld_o !== 1'b0 || busy_o !== 1'b0) begin fails++; $display("FAIL run3_gated vld=%b busy=%b exp=0/0", dec_data_vld_o, busy_o); end
    tick();
    #1;
    tests++; if (done_o !== 1'b0 || dec_data_vld_o !== 1'b0 || blocks_done_o !== 16'd3) begin fails++; $display("FAIL run3_idle done=%b vld=%b blocks=%0d exp=0/0/3", done_o, dec_data_vld_o, blocks_done_o); end
  endtask

  task automatic test_zero_blocks();
    start_job(16'd0);
    #1;
    tests++; if (dec_clr_o !== 1'b1 || dec_data_vld_o !== 1'b0 || done_o !== 1'b0) begin fails++; $display("FAIL zero_clear clr=%b vld=%b done=%b exp=1/0/0", dec_clr_o, dec_data_vld_o, done_o); end
    tick();
    #1;
    tests++; if (done_o !== 1'b1 || dec_data_vld_o !== 1'b0 || up_rdy_o !== 1'b0 || blocks_done_o !== '0) begin fails++; $display("FAIL zero_done done=%b vld=%b rdy=%b blocks=%0d exp=1/0/0/0", done_o, dec_data_vld_o, up_rdy_o, blocks_done_o); end
    tick();
    #1;
    tests++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin fails++; $display("FAIL zero_idle done=%b busy=%b exp=0/0", done_o, busy_o); end
  endtask

  task automatic test_push_cnt_err();
    start_job(16'd2);
    tick();
    for (int p = 0; p < PPB - 1; p++) begin
      dec_push_i = 1'b1;
      dec_vld_i  = (p == PPB - 2);
      tick();
    end
    dec_push_i = 1'b0; dec_vld_i = 1'b0;
    #1;
    tests++; if (err_o !== 1'b1 || err_code_o !== 2'd1 || dec_clr_o !== 1'b1) begin fails++; $display("FAIL pcnt_err err=%b code=%0d clr=%b exp=1/1/1", err_o, err_code_o, dec_clr_o); end
    tests++; if (busy_o !== 1'b0 || dec_rdy_o !== 1'b0 || dec_data_vld_o !== 1'b0) begin fails++; $display("FAIL pcnt_err_gate busy=%b drdy=%b vld=%b exp=0/0/0", busy_o, dec_rdy_o, dec_data_vld_o); end
    tick();
    #1;
    tests++; if (dec_clr_o !== 1'b0 || err_o !== 1'b1 || err_code_o !== 2'd1) begin fails++; $display("FAIL pcnt_err_hold clr=%b err=%b code=%0d exp=0/1/1", dec_clr_o, err_o, err_code_o); end
    start_job(16'd1);
    #1;
    tests++; if (err_o !== 1'b0 || err_code_o !== 2'd0 || busy_o !== 1'b1 || blocks_done_o !== '0) begin fails++; $display("FAIL pcnt_restart err=%b code=%0d busy=%b blocks=%0d exp=0/0/1/0", err_o, err_code_o, busy_o, blocks_done_o); end
    tick();
    for (int p = 0; p < PPB; p++) begin
      dec_push_i = 1'b1;
      dec_vld_i  = (p == PPB - 1);
      tick();
    end
    dec_push_i = 1'b0; dec_vld_i = 1'b0;
    #1;
    tests++; if (done_o !== 1'b1 || blocks_done_o !== 16'd1 || err_o !== 1'b0) begin fails++; $display("FAIL pcnt_newjob done=%b blocks=%0d err=%b exp=1/1/0", done_o, blocks_done_o, err_o); end
    tick();
  endtask

  task automatic test_abort();
    start_job(16'd4);
    tick();
    for (int p = 0; p < PPB; p++) begin
      dec_push_i = 1'b1;
      dec_vld_i  = (p == PPB - 1);
      tick();
    end
    dec_vld_i = 1'b0;
    // start while busy must not restart the job
    start_i = 1'b1; num_blocks_i = 16'd7;
    tick();
    start_i = 1'b0;
    repeat (2) tick();
    dec_push_i = 1'b0;
    abort_i    = 1'b1;
    #1;
    tests++; if (dec_clr_o !== 1'b1 || busy_o !== 1'b1 || blocks_done_o !== 16'd1) begin fails++; $display("FAIL abort_same_cycle clr=%b busy=%b blocks=%0d exp=1/1/1", dec_clr_o, busy_o, blocks_done_o); end
    tick();
    abort_i = 1'b0;
    #1;
    tests++; if (busy_o !== 1'b0 || dec_clr_o !== 1'b0 || err_o !== 1'b0 || blocks_done_o !== 16'd1) begin fails++; $display("FAIL abort_idle busy=%b clr=%b err=%b blocks=%0d exp=0/0/0/1", busy_o, dec_clr_o, err_o, blocks_done_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL abort_no_done cyc=%0d done=%b exp=0", i, done_o); end
    end
  endtask

  task automatic test_zero_run_gate();
    start_job(16'd1);
    tick();
    dec_push_i = 1'b1;
    tick();
    dec_data_rdy_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      tests++; if (dec_data_vld_o !== 1'b1 || up_rdy_o !== 1'b0) begin fails++; $display("FAIL zrun_gate cyc=%0d vld=%b rdy=%b exp=1/0", i, dec_data_vld_o, up_rdy_o); end
    end
    dec_data_rdy_i = 1'b1;
    for (int p = 0; p < 3; p++) begin
      dec_vld_i = (p == 2);
      tick();
    end
    dec_push_i = 1'b0; dec_vld_i = 1'b0;
    #1;
    tests++; if (done_o !== 1'b1 || err_o !== 1'b0 || dec_data_vld_o !== 1'b0 || up_rdy_o !== 1'b0) begin fails++; $display("FAIL zrun_end done=%b err=%b vld=%b rdy=%b exp=1/0/0/0", done_o, err_o, dec_data_vld_o, up_rdy_o); end
    tick();
  endtask

  task automatic test_watchdog();
    start_job(16'd1);
    tick();
    up_vld_i = 1'b1; ds_rdy_i = 1'b1; dec_push_i = 1'b0;
    repeat (15) tick();
    #1;
    tests++; if (err_o !== 1'b0 || busy_o !== 1'b1) begin fails++; $display("FAIL wd_pre err=%b busy=%b exp=0/1", err_o, busy_o); end
    tick();
    #1;
`ifdef EBPC_DEC_SEQ_WATCHDOG_EN
    tests++; if (err_o !== 1'b1 || err_code_o !== 2'd2 || dec_clr_o !== 1'b1) begin fails++; $display("FAIL wd_fire err=%b code=%0d clr=%b exp=1/2/1", err_o, err_code_o, dec_clr_o); end
`else
    tests++; if (err_o !== 1'b0 || err_code_o !== 2'd0 || busy_o !== 1'b1) begin fails++; $display("FAIL wd_off err=%b code=%0d busy=%b exp=0/0/1", err_o, err_code_o, busy_o); end
`endif
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    #1;
    tests++; if (busy_o !== 1'b0 || err_o !== 1'b0 || err_code_o !== 2'd0) begin fails++; $display("FAIL wd_cleanup busy=%b err=%b code=%0d exp=0/0/0", busy_o, err_o, err_code_o); end
  endtask

  initial begin
    test_reset();
    test_three_blocks();
    test_zero_blocks();
    test_push_cnt_err();
    test_abort();
    test_zero_run_gate();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
